// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the shared scan-coordinate type.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows, both ends inclusive.
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_delay_line.sv
// Resettable shift register that realigns sync/blank with the draw pipeline.
module vga_delay_line #(
  parameter int unsigned           WIDTH     = 3,
  parameter int unsigned           DEPTH     = 2,
  parameter logic [WIDTH-1:0]      RESET_VAL = '1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    // Zero depth is a plain wire; clock and reset are intentionally unused.
    logic unused_clk_rst;
    assign unused_clk_rst = ^{vga_clk, reset_n};
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; reset clears every stage at once.
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q[0] <= din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Scan-position counters plus registered sync, blank and strobe decode.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP       = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP       = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_timing_pkg::V_BP,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  import vga_timing_pkg::*;

  localparam int unsigned HTotal  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;

  localparam coord_t HLast   = coord_t'(HTotal - 1);
  localparam coord_t VLast   = coord_t'(VTotal - 1);
  localparam coord_t HActive = coord_t'(H_ACTIVE);
  localparam coord_t VActive = coord_t'(V_ACTIVE);
  localparam coord_t HsFirst = coord_t'(HsStart);
  localparam coord_t HsLast  = coord_t'(HsStart + H_SYNC - 1);
  localparam coord_t VsFirst = coord_t'(VsStart);
  localparam coord_t VsLast  = coord_t'(VsStart + V_SYNC - 1);

  if (HTotal > 1024 || VTotal > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H/V totals must fit the 10-bit counters");
  end

  coord_t     draw_x_q, draw_x_d;
  coord_t     draw_y_q, draw_y_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       vid_on_q, vid_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [2:0] sync_dly;

  // Next scan position; the frame counter bumps on the wrap back to (0,0).
  always_comb begin
    draw_x_d      = draw_x_q + 10'd1;
    draw_y_d      = draw_y_q;
    frame_count_d = frame_count_q;
    if (draw_x_q == HLast) begin
      draw_x_d = '0;
      if (draw_y_q == VLast) begin
        draw_y_d      = '0;
        frame_count_d = frame_count_q + 8'd1;
      end else begin
        draw_y_d = draw_y_q + 10'd1;
      end
    end
  end

  // Decode from the next position so the flags line up with the counters.
  always_comb begin
    hsync_d       = !((draw_x_d >= HsFirst) && (draw_x_d <= HsLast));
    vsync_d       = !((draw_y_d >= VsFirst) && (draw_y_d <= VsLast));
    vid_on_d      = (draw_x_d < HActive) && (draw_y_d < VActive);
    line_start_d  = (draw_x_d == '0);
    frame_start_d = (draw_x_d == '0) && (draw_y_d == '0);
  end

  // Counter and flag registers; reset presents the (0,0) cycle.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      frame_count_q <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vid_on_q      <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vid_on_q      <= vid_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (3'b111)
  ) u_sync_dly (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .din     ({hsync_q, vsync_q, vid_on_q}),
    .dout    (sync_dly)
  );

  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign frame_count = frame_count_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign blank       = vid_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hs_d        = sync_dly[2];
  assign vs_d        = sync_dly[1];
  assign blank_d     = sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full-size timing instance plus a shrunken-frame instance.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       hs_d;
    logic       vs_d;
    logic       blank_d;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    bit    dut;   // 0 = full-size instance, 1 = small instance
    obs_t  exp;
    string name;
  } entry_t;

  entry_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic vga_clk = 1'b0;
  logic rst_d_n;
  logic rst_s_n;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_blank, d_hs, d_vs, d_hs_d, d_vs_d, d_blank_d, d_ls, d_fs;
  logic       s_blank, s_hs, s_vs, s_hs_d, s_vs_d, s_blank_d, s_ls, s_fs;
  logic [7:0] d_fc, s_fc;
  obs_t       obs_def, obs_sm;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen u_dut (
    .vga_clk     (vga_clk),
    .reset_n     (rst_d_n),
    .DrawX       (d_x),
    .DrawY       (d_y),
    .blank       (d_blank),
    .hs          (d_hs),
    .vs          (d_vs),
    .hs_d        (d_hs_d),
    .vs_d        (d_vs_d),
    .blank_d     (d_blank_d),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_count (d_fc)
  );

  // 15x11 frame: HS at x 10..12, VS at y 7..8, active 8x6, no delay.
  vga_timing_gen #(
    .H_ACTIVE   (8),
    .H_FP       (2),
    .H_SYNC     (3),
    .H_BP       (2),
    .V_ACTIVE   (6),
    .V_FP       (1),
    .V_SYNC     (2),
    .V_BP       (2),
    .SYNC_DELAY (0)
  ) u_dut_sm (
    .vga_clk     (vga_clk),
    .reset_n     (rst_s_n),
    .DrawX       (s_x),
    .DrawY       (s_y),
    .blank       (s_blank),
    .hs          (s_hs),
    .vs          (s_vs),
    .hs_d        (s_hs_d),
    .vs_d        (s_vs_d),
    .blank_d     (s_blank_d),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_count (s_fc)
  );

  assign obs_def = {d_x, d_y, d_blank, d_hs, d_vs, d_hs_d, d_vs_d, d_blank_d, d_ls, d_fs, d_fc};
  assign obs_sm  = {s_x, s_y, s_blank, s_hs, s_vs, s_hs_d, s_vs_d, s_blank_d, s_ls, s_fs, s_fc};

  function automatic obs_t mk(int x, int y, bit b, bit h, bit v, bit hd, bit vd, bit bd,
                              bit ls, bit fs, int fc);
    obs_t o;
    o.x = 10'(x); o.y = 10'(y); o.blank = b; o.hs = h; o.vs = v;
    o.hs_d = hd; o.vs_d = vd; o.blank_d = bd; o.ls = ls; o.fs = fs; o.fc = 8'(fc);
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("(x=%0d y=%0d blank=%0b hs=%0b vs=%0b hs_d=%0b vs_d=%0b blank_d=%0b ls=%0b fs=%0b fc=%0d)",
                     o.x, o.y, o.blank, o.hs, o.vs, o.hs_d, o.vs_d, o.blank_d, o.ls, o.fs, o.fc);
  endfunction

  task automatic push(bit dut, string name, obs_t e);
    entry_t en;
    en.dut  = dut;
    en.exp  = e;
    en.name = name;
    sb_q.push_back(en);
  endtask

  task automatic check_int(string name, int got, int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Monitor: every queued expectation is compared on the falling edge.
  always @(negedge vga_clk) begin
    while (sb_q.size() > 0) begin
      entry_t e;
      obs_t   got;
      e   = sb_q.pop_front();
      got = e.dut ? obs_sm : obs_def;
      n_checks++;
      if (got == e.exp) n_pass++;
      else $display("FAIL %s: got %s want %s", e.name, fmt(got), fmt(e.exp));
    end
  end

  // Full-size instance, first run: hand-computed points along lines 0..2.
  task automatic def_vec0(int dn);
    obs_t e;
    bit   hit = 1'b1;
    case (dn)
      1:       e = mk(1,   0, 1, 1, 1, 1, 1, 1, 0, 0, 0);
      2:       e = mk(2,   0, 1, 1, 1, 1, 1, 1, 0, 0, 0);
      639:     e = mk(639, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0);
      640:     e = mk(640, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0);
      641:     e = mk(641, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0);
      642:     e = mk(642, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
      655:     e = mk(655, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
      656:     e = mk(656, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      657:     e = mk(657, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      658:     e = mk(658, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      751:     e = mk(751, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      752:     e = mk(752, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
      753:     e = mk(753, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
      754:     e = mk(754, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
      799:     e = mk(799, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
      800:     e = mk(0,   1, 1, 1, 1, 1, 1, 0, 1, 0, 0);
      802:     e = mk(2,   1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
      2299:    e = mk(699, 2, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      default: hit = 1'b0;
    endcase
    if (hit) push(1'b0, $sformatf("def_n%0d", dn), e);
  endtask

  // Full-size instance after the mid-frame reset: counting restarts cleanly.
  task automatic def_vec1(int dn);
    obs_t e;
    bit   hit = 1'b1;
    case (dn)
      1:       e = mk(1, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0);
      800:     e = mk(0, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0);
      default: hit = 1'b0;
    endcase
    if (hit) push(1'b0, $sformatf("def_rerun_n%0d", dn), e);
  endtask

  // Small instance: 165 clocks per frame.
  task automatic sm_vec(int n);
    obs_t e;
    bit   hit = 1'b1;
    case (n)
      10:      e = mk(10, 0,  0, 0, 1, 0, 1, 0, 0, 0, 0);
      13:      e = mk(13, 0,  0, 1, 1, 1, 1, 0, 0, 0, 0);
      90:      e = mk(0,  6,  0, 1, 1, 1, 1, 0, 1, 0, 0);
      105:     e = mk(0,  7,  0, 1, 0, 1, 0, 0, 1, 0, 0);
      134:     e = mk(14, 8,  0, 1, 0, 1, 0, 0, 0, 0, 0);
      135:     e = mk(0,  9,  0, 1, 1, 1, 1, 0, 1, 0, 0);
      164:     e = mk(14, 10, 0, 1, 1, 1, 1, 0, 0, 0, 0);
      165:     e = mk(0,  0,  1, 1, 1, 1, 1, 1, 1, 1, 1);
      172:     e = mk(7,  0,  1, 1, 1, 1, 1, 1, 0, 0, 1);
      173:     e = mk(8,  0,  0, 1, 1, 1, 1, 0, 0, 0, 1);
      42075:   e = mk(0,  0,  1, 1, 1, 1, 1, 1, 1, 1, 255);
      42239:   e = mk(14, 10, 0, 1, 1, 1, 1, 0, 0, 0, 255);
      42240:   e = mk(0,  0,  1, 1, 1, 1, 1, 1, 1, 1, 0);
      default: hit = 1'b0;
    endcase
    if (hit) push(1'b1, $sformatf("sm_n%0d", n), e);
  endtask

  initial begin : stim
    obs_t rst_exp;
    int   dn;
    bit   ph;
    int   rel_at;
    int   d_hs_lo, d_hsd_lo, s_vs_lo, s_vsd_lo, s_blank_lo, s_fs_cnt;

    rst_exp = mk(0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0);
    dn = 0; ph = 1'b0; rel_at = 0;
    d_hs_lo = 0; d_hsd_lo = 0; s_vs_lo = 0; s_vsd_lo = 0; s_blank_lo = 0; s_fs_cnt = 0;

    rst_d_n = 1'b0;
    rst_s_n = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    push(1'b0, "def_in_reset", rst_exp);
    push(1'b1, "sm_in_reset", rst_exp);

    // Release between edges; the following falling edge sees the first active cycle.
    @(posedge vga_clk);
    #2;
    rst_d_n = 1'b1;
    rst_s_n = 1'b1;
    push(1'b0, "def_n0", rst_exp);
    push(1'b1, "sm_n0", rst_exp);

    for (int n = 1; n <= 42240; n++) begin
      @(posedge vga_clk);
      #1;
      sm_vec(n);
      if (n <= 165) begin
        if (!s_vs)    s_vs_lo++;
        if (!s_vs_d)  s_vsd_lo++;
        if (!s_blank) s_blank_lo++;
      end
      if (s_fs) s_fs_cnt++;

      if (rst_d_n) begin
        dn++;
        if (!ph && dn == 2300) begin
          // DrawX=700, DrawY=2: drop reset mid-cycle, no clock edge before sampling.
          #1;
          rst_d_n = 1'b0;
          push(1'b0, "def_midframe_reset", rst_exp);
          rel_at = n + 4;
          ph = 1'b1;
        end else if (!ph) begin
          def_vec0(dn);
          if (dn <= 799) begin
            if (!d_hs)   d_hs_lo++;
            if (!d_hs_d) d_hsd_lo++;
          end
        end else begin
          def_vec1(dn);
        end
      end else if (n == rel_at) begin
        #1;
        rst_d_n = 1'b1;
        dn = 0;
        push(1'b0, "def_rerun_n0", rst_exp);
      end else begin
        push(1'b0, $sformatf("def_held_reset_n%0d", n), rst_exp);
      end
    end

    @(negedge vga_clk);
    #1;
    check_int("scoreboard_drained", sb_q.size(), 0);
    check_int("def_hs_low_clocks_line0", d_hs_lo, 96);
    check_int("def_hs_d_low_clocks_line0", d_hsd_lo, 96);
    check_int("sm_vs_low_clocks_frame0", s_vs_lo, 30);
    check_int("sm_vs_d_low_clocks_frame0", s_vsd_lo, 30);
    check_int("sm_blank_low_clocks_frame0", s_blank_lo, 117);
    check_int("sm_frame_start_count", s_fs_cnt, 256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
